// File: rtl/sudoku_pkg.sv
// Shared sizing, FSM state encoding and board helpers for the sudoku board checker.
// Pure declarations: no latency, no flow control.
package sudoku_pkg;
   localparam int BOX     = 2;
   localparam int N       = BOX * BOX;
   localparam int CELL_W  = 6;
   localparam int DIGIT_W = 4;
   localparam int ADDR_W  = $clog2(N);
   localparam int UNIT_W  = $clog2(3 * N);

   typedef enum logic [1:0] {IDLE, READ, CHECK, DONE} state_t;

   typedef logic [DIGIT_W-1:0]        digit_t;
   typedef logic [N-1:0][DIGIT_W-1:0] row_t;
   typedef logic [N-1:0][CELL_W-1:0]  word_t;

   // Keeps only the digit field of each cell; protect flags above it are dropped.
   function automatic row_t cell_extract(input word_t word);
      row_t r;
      for (int c = 0; c < N; c++) begin
         r[c] = word[c][DIGIT_W-1:0];
      end
      return r;
   endfunction

   function automatic int box_row0(input int b);
      return (b / BOX) * BOX;
   endfunction

   function automatic int box_col0(input int b);
      return (b % BOX) * BOX;
   endfunction
endpackage

// File: rtl/sudoku_unit_check.sv
// Combinational check of one row/column/box: full = no empty cell, dup = repeated or out-of-range digit.
// Zero latency; no flow control.
module sudoku_unit_check
   import sudoku_pkg::*;
(
   input  logic [N*DIGIT_W-1:0] digits_i,
   output logic                 full_o,
   output logic                 dup_o
);
   localparam digit_t N_DIG = digit_t'(N);

   row_t                  digits;
   logic [2**DIGIT_W-1:0] seen;
   digit_t                d;

   assign digits = digits_i;

   always_comb begin
      seen   = '0;
      full_o = 1'b1;
      dup_o  = 1'b0;
      d      = '0;
      for (int k = 0; k < N; k++) begin
         d = digits[k];
         if (d == '0) begin
            full_o = 1'b0;
         end else if (d > N_DIG) begin
            dup_o = 1'b1;
         end else begin
            if (seen[d - digit_t'(1)]) dup_o = 1'b1;
            seen[d - digit_t'(1)] = 1'b1;
         end
      end
   end
endmodule

// File: rtl/sudoku_board_checker.sv
// Scans the board one row per cycle into a local buffer, then checks one unit per cycle.
// Scan period 4N+RD_LAT+1 cycles; enable is only sampled in IDLE/DONE, no backpressure.
module sudoku_board_checker
   import sudoku_pkg::*;
#(
   parameter int RD_LAT = 1
)(
   input  logic                CLK,
   input  logic                RST,
   input  logic                enable,
   output logic [ADDR_W-1:0]   RamAddr,
   input  logic [N*CELL_W-1:0] RamDat,
   output logic                gameComplete,
   output logic                boardFull,
   output logic                conflict,
   output logic                badValid,
   output logic [UNIT_W-1:0]   badUnit,
   output logic                scanDone,
   output logic                busy
);
   localparam int CNT_W = $clog2(N + RD_LAT + 1);

   state_t                     state_q, state_d;
   logic [CNT_W-1:0]           rd_cnt_q, rd_cnt_d;
   logic [ADDR_W-1:0]          addr_q, addr_d;
   logic [UNIT_W-1:0]          unit_q, unit_d;
   logic [N-1:0][N-1:0][DIGIT_W-1:0] grid_q, grid_d;

   logic                       empty_acc_q, empty_acc_d;
   logic                       dup_acc_q, dup_acc_d;
   logic                       bad_acc_q, bad_acc_d;
   logic [UNIT_W-1:0]          bad_unit_acc_q, bad_unit_acc_d;

   logic                       complete_q, complete_d;
   logic                       full_q, full_d;
   logic                       conflict_q, conflict_d;
   logic                       bad_vld_q, bad_vld_d;
   logic [UNIT_W-1:0]          bad_unit_q, bad_unit_d;

   row_t                       ram_row;
   row_t                       unit_dig;
   logic                       unit_full, unit_dup;
   logic                       start;

   assign ram_row = cell_extract(RamDat);

   // Unit select: rows, then columns, then boxes in row-major box order.
   always_comb begin
      unit_dig = '0;
      for (int u = 0; u < N; u++) begin
         if (unit_q == UNIT_W'(u)) begin
            for (int k = 0; k < N; k++) unit_dig[k] = grid_q[u][k];
         end
      end
      for (int u = 0; u < N; u++) begin
         if (unit_q == UNIT_W'(N + u)) begin
            for (int k = 0; k < N; k++) unit_dig[k] = grid_q[k][u];
         end
      end
      for (int b = 0; b < N; b++) begin
         if (unit_q == UNIT_W'(2 * N + b)) begin
            for (int k = 0; k < N; k++) begin
               unit_dig[k] = grid_q[box_row0(b) + k / BOX][box_col0(b) + k % BOX];
            end
         end
      end
   end

   sudoku_unit_check u_check (
      .digits_i (unit_dig),
      .full_o   (unit_full),
      .dup_o    (unit_dup)
   );

   always_comb begin
      state_d        = state_q;
      rd_cnt_d       = rd_cnt_q;
      addr_d         = addr_q;
      unit_d         = unit_q;
      grid_d         = grid_q;
      empty_acc_d    = empty_acc_q;
      dup_acc_d      = dup_acc_q;
      bad_acc_d      = bad_acc_q;
      bad_unit_acc_d = bad_unit_acc_q;
      complete_d     = complete_q;
      full_d         = full_q;
      conflict_d     = conflict_q;
      bad_vld_d      = bad_vld_q;
      bad_unit_d     = bad_unit_q;
      start          = 1'b0;

      case (state_q)
         IDLE: begin
            if (enable) start = 1'b1;
         end
         READ: begin
            rd_cnt_d = rd_cnt_q + 1'b1;
            if (addr_q != ADDR_W'(N - 1)) addr_d = addr_q + 1'b1;
            // Row r arrives RD_LAT cycles after its address went out.
            for (int r = 0; r < N; r++) begin
               if (rd_cnt_q == CNT_W'(r + RD_LAT)) grid_d[r] = ram_row;
            end
            if (rd_cnt_q == CNT_W'(N + RD_LAT - 1)) begin
               state_d = CHECK;
               unit_d  = '0;
            end
         end
         CHECK: begin
            empty_acc_d = empty_acc_q | ~unit_full;
            dup_acc_d   = dup_acc_q | unit_dup;
            if ((~unit_full | unit_dup) & ~bad_acc_q) begin
               bad_acc_d      = 1'b1;
               bad_unit_acc_d = unit_q;
            end
            unit_d = unit_q + 1'b1;
            if (unit_q == UNIT_W'(3 * N - 1)) begin
               state_d    = DONE;
               unit_d     = '0;
               complete_d = ~empty_acc_d & ~dup_acc_d;
               full_d     = ~empty_acc_d;
               conflict_d = dup_acc_d;
               bad_vld_d  = bad_acc_d;
               bad_unit_d = bad_unit_acc_d;
            end
         end
         DONE: begin
            if (enable) start   = 1'b1;
            else        state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (start) begin
         state_d        = READ;
         rd_cnt_d       = '0;
         addr_d         = '0;
         empty_acc_d    = 1'b0;
         dup_acc_d      = 1'b0;
         bad_acc_d      = 1'b0;
         bad_unit_acc_d = '0;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q        <= IDLE;
         rd_cnt_q       <= '0;
         addr_q         <= '0;
         unit_q         <= '0;
         grid_q         <= '0;
         empty_acc_q    <= 1'b0;
         dup_acc_q      <= 1'b0;
         bad_acc_q      <= 1'b0;
         bad_unit_acc_q <= '0;
         complete_q     <= 1'b0;
         full_q         <= 1'b0;
         conflict_q     <= 1'b0;
         bad_vld_q      <= 1'b0;
         bad_unit_q     <= '0;
      end else begin
         state_q        <= state_d;
         rd_cnt_q       <= rd_cnt_d;
         addr_q         <= addr_d;
         unit_q         <= unit_d;
         grid_q         <= grid_d;
         empty_acc_q    <= empty_acc_d;
         dup_acc_q      <= dup_acc_d;
         bad_acc_q      <= bad_acc_d;
         bad_unit_acc_q <= bad_unit_acc_d;
         complete_q     <= complete_d;
         full_q         <= full_d;
         conflict_q     <= conflict_d;
         bad_vld_q      <= bad_vld_d;
         bad_unit_q     <= bad_unit_d;
      end
   end

   assign RamAddr      = addr_q;
   assign gameComplete = complete_q;
   assign boardFull    = full_q;
   assign conflict     = conflict_q;
   assign badValid     = bad_vld_q;
   assign badUnit      = bad_unit_q;
   assign scanDone     = (state_q == DONE);
   assign busy         = (state_q == READ) || (state_q == CHECK);
endmodule
